rf_wb_arbiter: RTL



---
 rtl/rf_wb_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the 32x32 register file: shares one write port between
// the ALU and LSU, drives a registered write stage and keeps a pending-write scoreboard.
module rf_wb_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_addr_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic        hazard_o,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_addr_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  logic        r_last_lsu;
  logic        r_we;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;
  logic [31:0] r_busy;

  logic        w_alu_gnt;
  logic        w_lsu_gnt;
  logic        w_any_gnt;
  logic [4:0]  w_gnt_addr;
  logic [31:0] w_gnt_data;
  logic        w_issue_ok;
  logic [31:0] w_set;
  logic [31:0] w_clr;
  logic [31:0] w_busy_nxt;

  // Handshake: a source transfers when valid && ready; ready depends only on the
  // valids and the last grant, and a waiting source holds valid/addr/data stable.
  always_comb begin
    w_alu_gnt  = alu_valid_i & (~lsu_valid_i | (RR_EN == 1'b0) | r_last_lsu);
    w_lsu_gnt  = lsu_valid_i & ~w_alu_gnt;
    w_any_gnt  = w_alu_gnt | w_lsu_gnt;
    w_gnt_addr = w_alu_gnt ? alu_addr_i : lsu_addr_i;
    w_gnt_data = w_alu_gnt ? alu_data_i : lsu_data_i;
  end

  assign alu_ready_o = w_alu_gnt;
  assign lsu_ready_o = w_lsu_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_lsu <= 1'b1;
    end else if (w_any_gnt) begin
      r_last_lsu <= w_lsu_gnt;
    end
  end

  // x0 requests are acknowledged but never raise the write enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
    end else begin
      r_we <= w_any_gnt & (w_gnt_addr != 5'd0);
      if (w_any_gnt) begin
        r_waddr <= w_gnt_addr;
        r_wdata <= w_gnt_data;
      end
    end
  end

  assign rf_we_o    = r_we;
  assign rf_waddr_o = r_waddr;
  assign rf_wdata_o = r_wdata;

  // Bit 0 of r_busy is never set, so x0 sources never stall decode.
  assign hazard_o   = r_busy[rs1_addr_i] | r_busy[rs2_addr_i] |
                      (issue_valid_i & r_busy[issue_addr_i]);
  assign w_issue_ok = issue_valid_i & ~hazard_o & (issue_addr_i != 5'd0);

  always_comb begin
    w_set      = w_issue_ok ? (32'd1 << issue_addr_i) : 32'd0;
    w_clr      = r_we ? (32'd1 << r_waddr) : 32'd0;
    w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

endmodule
